// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter_if
//  Purpose  : Bundle of requester-side and display-side signals shared by the
//             four requesters and the seven-segment display arbiter.
//  Signals  : req      [3:0]  level request per requester
//             data     [63:0] packed values, requester i on data[16*i+:16]
//             grant    [3:0]  one-hot grant (all zero when idle)
//             owner    [1:0]  current or last owner index
//             disp_bin [15:0] value for the seven-segment driver
//             disp_en         display enable (0 = blank)
//             switch          one-cycle pulse on every new grant
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface seg_display_arbiter_if;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [15:0] disp_bin;
  logic        disp_en;
  logic        switch;

  modport master (
    output req, data,
    input  grant, owner, disp_bin, disp_en, switch
  );

  modport slave (
    input  req, data,
    output grant, owner, disp_bin, disp_en, switch
  );
endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter
//  Purpose  : Round-robin time-sharing of one four-digit seven-segment display
//             between four requesters, with a guaranteed minimum dwell time.
//  Ports    : clk    system clock, rising edge
//             reset  asynchronous reset, active low
//             bus    seg_display_arbiter_if.slave (req/data in,
//                    grant/owner/disp_bin/disp_en/switch out, all registered)
//  Params   : HOLD_CYCLES  minimum cycles a granted requester keeps the display
//             CNT_W        dwell counter width, 2**CNT_W > HOLD_CYCLES-1
//  Revision : 1.0  initial release
// ============================================================================
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_owner;
  logic [15:0]      r_bin;
  logic             r_en;
  logic             r_switch;

  logic [3:0]       w_others;
  logic [2:0]       w_idle_pick;
  logic [2:0]       w_busy_pick;
  logic             w_release;
  logic             w_take;
  logic [1:0]       w_win;

  // Returns {found, index} of the first set bit of r visiting start,
  // start+1, start+2, start+3 (mod 4). Iterating from the far end lets
  // the nearest candidate overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [15:0] pick_slice(input logic [63:0] d, input logic [1:0] i);
    logic [15:0] s;
    case (i)
      2'd0:    s = d[15:0];
      2'd1:    s = d[31:16];
      2'd2:    s = d[47:32];
      default: s = d[63:48];
    endcase
    return s;
  endfunction

  // The owner's own bit is masked out, so the busy-state search from owner+1
  // only ever visits the three other requesters.
  assign w_others    = bus.req & ~(4'b0001 << r_owner);
  assign w_idle_pick = rr_pick(bus.req, r_ptr);
  assign w_busy_pick = rr_pick(w_others, r_owner + 2'd1);
  assign w_release   = ~bus.req[r_owner];

  // A new grant happens from IDLE on any request, in HOLD only once the
  // dwell has expired or the owner let go, and in OPEN on any other request.
  always_comb begin
    w_take = 1'b0;
    w_win  = r_owner;
    case (r_state)
      ST_IDLE: begin
        w_take = w_idle_pick[2];
        w_win  = w_idle_pick[1:0];
      end
      ST_HOLD: begin
        w_take = (w_release || (r_cnt == '0)) && w_busy_pick[2];
        w_win  = w_busy_pick[1:0];
      end
      ST_OPEN: begin
        w_take = w_busy_pick[2];
        w_win  = w_busy_pick[1:0];
      end
      default: begin
        w_take = 1'b0;
        w_win  = r_owner;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd0;
      r_cnt    <= '0;
      r_grant  <= 4'b0000;
      r_owner  <= 2'd0;
      r_bin    <= 16'h0000;
      r_en     <= 1'b0;
      r_switch <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      if (w_take) begin
        r_state  <= ST_HOLD;
        r_grant  <= 4'b0001 << w_win;
        r_owner  <= w_win;
        r_cnt    <= c_cnt_load;
        r_bin    <= pick_slice(bus.data, w_win);
        r_en     <= 1'b1;
        r_switch <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_en  <= 1'b0;
            r_bin <= 16'h0000;
          end
          ST_HOLD, ST_OPEN: begin
            if (w_release) begin
              // Nobody else waiting: blank, keep owner, resume search after it.
              r_state <= ST_IDLE;
              r_grant <= 4'b0000;
              r_en    <= 1'b0;
              r_bin   <= 16'h0000;
              r_ptr   <= r_owner + 2'd1;
            end else begin
              r_bin <= pick_slice(bus.data, r_owner);
              if (r_state == ST_HOLD) begin
                if (r_cnt == '0) r_state <= ST_OPEN;
                else             r_cnt   <= r_cnt - c_cnt_one;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_en    <= 1'b0;
            r_bin   <= 16'h0000;
          end
        endcase
      end
    end
  end

  assign bus.grant    = r_grant;
  assign bus.owner    = r_owner;
  assign bus.disp_bin = r_bin;
  assign bus.disp_en  = r_en;
  assign bus.switch   = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_arbiter
//  Purpose  : Self-checking bench for seg_display_arbiter (HOLD_CYCLES = 4):
//             directed vector table, async-reset sequence and a randomized
//             run checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_display_arbiter;
  localparam int HOLD = 4;
  localparam logic [63:0] D0 = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
  localparam logic [63:0] DB = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};

  logic clk   = 1'b0;
  logic reset = 1'b0;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    bit          rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  g;
    logic [1:0]  o;
    logic [15:0] b;
    logic        e;
    logic        s;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string name, bit rst, logic [3:0] req, logic [63:0] data,
                              logic [3:0] g, logic [1:0] o, logic [15:0] b, logic e, logic s);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.data = data;
    v.g = g; v.o = o; v.b = b; v.e = e; v.s = s;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] g, logic [1:0] o, logic [15:0] b, logic e, logic s);
    n_cmp++;
    if ({bus.grant, bus.owner, bus.disp_bin, bus.disp_en, bus.switch} !== {g, o, b, e, s}) begin
      n_bad++;
      $display("FAIL %s @%0t: got grant=%b owner=%0d bin=%h en=%b sw=%b, want grant=%b owner=%0d bin=%h en=%b sw=%b",
               name, $time, bus.grant, bus.owner, bus.disp_bin, bus.disp_en, bus.switch, g, o, b, e, s);
    end
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    bus.data = D0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Apply inputs, let one rising edge take them, observe 1 time unit later.
  task automatic step(logic [3:0] req, logic [63:0] data);
    bus.req  = req;
    bus.data = data;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_busy, m_owner, m_ptr, m_held;
  logic [15:0] m_bin;
  logic        m_sw;

  function automatic logic [15:0] slice16(logic [63:0] d, int i);
    return d[16*i +: 16];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_bin = 16'h0; m_sw = 1'b0;
  endtask

  task automatic model_grant(int w, logic [63:0] d);
    m_owner = w; m_busy = 1; m_held = 0; m_sw = 1'b1; m_bin = slice16(d, w);
  endtask

  task automatic model_edge(logic [3:0] r, logic [63:0] d);
    int  win;
    bit  found;
    m_sw = 1'b0;
    win = 0; found = 0;
    if (m_busy == 0) begin
      for (int k = 0; k < 4; k++)
        if (!found && r[(m_ptr + k) % 4]) begin found = 1; win = (m_ptr + k) % 4; end
      if (found) model_grant(win, d);
      else m_bin = 16'h0;
    end else begin
      m_held++;
      for (int k = 1; k < 4; k++)
        if (!found && r[(m_owner + k) % 4]) begin found = 1; win = (m_owner + k) % 4; end
      if (!r[m_owner]) begin
        if (found) model_grant(win, d);
        else begin m_busy = 0; m_ptr = (m_owner + 1) % 4; m_bin = 16'h0; end
      end else if (m_held >= HOLD && found) begin
        model_grant(win, d);
      end else begin
        m_bin = slice16(d, m_owner);
      end
    end
  endtask

  initial begin
    logic [3:0]  r;
    logic [63:0] d;
    logic [3:0]  oh;

    // ---- directed vector table ----
    add("single_grant", 1, 4'b0001, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);
    add("single_data",  0, 4'b0001, DB, 4'b0001, 2'd0, 16'hBEEF, 1, 0);
    add("single_rel",   0, 4'b0000, D0, 4'b0000, 2'd0, 16'h0000, 0, 0);

    add("cont_grant0",  1, 4'b0011, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);
    for (int i = 0; i < 3; i++)
      add("cont_dwell0", 0, 4'b0011, D0, 4'b0001, 2'd0, 16'h1234, 1, 0);
    add("cont_grant1",  0, 4'b0011, D0, 4'b0010, 2'd1, 16'h2222, 1, 1);
    add("cont_dwell1",  0, 4'b0011, D0, 4'b0010, 2'd1, 16'h2222, 1, 0);

    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int c = 0; c < 4; c++)
        if (g < 4 || c == 0)
          add("rotation", (g == 0 && c == 0), 4'b1111, D0, oh, 2'(g % 4),
              slice16(D0, g % 4), 1, (c == 0));
    end

    add("early_grant0", 1, 4'b0101, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);
    add("early_hold0",  0, 4'b0101, D0, 4'b0001, 2'd0, 16'h1234, 1, 0);
    add("early_rel",    0, 4'b0100, D0, 4'b0100, 2'd2, 16'h3333, 1, 1);
    for (int i = 0; i < 3; i++)
      add("early_reload", 0, 4'b0101, D0, 4'b0100, 2'd2, 16'h3333, 1, 0);
    add("early_next",   0, 4'b0101, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);

    add("open_grant",   1, 4'b0001, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);
    for (int i = 0; i < 9; i++)
      add("open_stable", 0, 4'b0001, D0, 4'b0001, 2'd0, 16'h1234, 1, 0);
    add("open_preempt", 0, 4'b1001, D0, 4'b1000, 2'd3, 16'h4444, 1, 1);
    add("open_idle",    0, 4'b0000, D0, 4'b0000, 2'd3, 16'h0000, 0, 0);
    add("open_ptr",     0, 4'b1001, D0, 4'b0001, 2'd0, 16'h1234, 1, 1);

    bus.req = 4'b0000;
    bus.data = D0;
    #12;
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", 4'b0000, 2'd0, 16'h0000, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req, tbl[i].data);
      check(tbl[i].name, tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].e, tbl[i].s);
    end

    // ---- asynchronous reset mid-grant ----
    do_reset();
    step(4'b0010, D0);
    check("async_pre", 4'b0010, 2'd1, 16'h2222, 1, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", 4'b0000, 2'd0, 16'h0000, 0, 0);
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    step(4'b0000, D0);
    step(4'b0000, D0);
    check("async_idle", 4'b0000, 2'd0, 16'h0000, 0, 0);

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    r = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
      d = {$urandom, $urandom};
      step(r, d);
      model_edge(r, d);
      check("random", m_busy ? (4'b0001 << m_owner) : 4'b0000, 2'(m_owner),
            m_bin, (m_busy != 0), m_sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
